// File: rtl/ps2_kbd_ctrl_pkg.sv
// rtl/ps2_kbd_ctrl_pkg.sv - shared scan codes, FSM states and helpers for the PS/2 keyboard controller
package ps2_kbd_ctrl_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_DEC  = 2'd2
    } state_t;

    function automatic logic is_prefix(input logic [7:0] code);
        return (code == SC_BREAK) || (code == SC_EXT);
    endfunction

    function automatic logic is_shift(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// rtl/ps2_scan2ascii.sv - combinational scan-code set 2 to ASCII lookup
//
// Ports:
//   code   in  8  scan code of the held/last key
//   ext    in  1  code arrived with an E0 prefix (extended keys map to 0)
//   shift  in  1  either shift key held
//   caps   in  1  caps-lock state
//   ascii  out 8  ASCII character, 8'h00 when the key has no mapping
module ps2_scan2ascii (
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    // Each entry holds {unshifted, shifted} characters.
    logic [15:0] pair;
    logic        letter;
    logic        use_upper;

    always_comb begin
        pair = 16'h0000;
        case (code)
            8'h1C: pair = "aA";
            8'h32: pair = "bB";
            8'h21: pair = "cC";
            8'h23: pair = "dD";
            8'h24: pair = "eE";
            8'h2B: pair = "fF";
            8'h34: pair = "gG";
            8'h33: pair = "hH";
            8'h43: pair = "iI";
            8'h3B: pair = "jJ";
            8'h42: pair = "kK";
            8'h4B: pair = "lL";
            8'h3A: pair = "mM";
            8'h31: pair = "nN";
            8'h44: pair = "oO";
            8'h4D: pair = "pP";
            8'h15: pair = "qQ";
            8'h2D: pair = "rR";
            8'h1B: pair = "sS";
            8'h2C: pair = "tT";
            8'h3C: pair = "uU";
            8'h2A: pair = "vV";
            8'h1D: pair = "wW";
            8'h22: pair = "xX";
            8'h35: pair = "yY";
            8'h1A: pair = "zZ";
            8'h45: pair = "0)";
            8'h16: pair = "1!";
            8'h1E: pair = "2@";
            8'h26: pair = "3#";
            8'h25: pair = "4$";
            8'h2E: pair = "5%";
            8'h36: pair = "6^";
            8'h3D: pair = "7&";
            8'h3E: pair = "8*";
            8'h46: pair = "9(";
            8'h29: pair = "  ";
            8'h5A: pair = 16'h0D0D;
            8'h4E: pair = "-_";
            8'h55: pair = "=+";
            default: pair = 16'h0000;
        endcase
    end

    // Caps lock only affects letters; digits and symbols follow shift alone.
    assign letter    = (pair[15:8] >= "a") && (pair[15:8] <= "z");
    assign use_upper = letter ? (shift ^ caps) : shift;
    assign ascii     = ext ? 8'h00 : (use_upper ? pair[7:0] : pair[15:8]);

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 receiver FIFO consumer: prefix stripping, key/shift/caps tracking, events
//
// Ports:
//   clk, clrn            clock, async active-low reset
//   rx_ready/rx_data     receiver FIFO non-empty flag and head byte
//   rx_overflow          receiver overflow level
//   nextdata_n           active-low pop strobe, one clock per byte
//   key_event/release    one-clock make (non-repeat) / release pulses
//   key_code/key_ext     last make code and its E0 flag
//   key_down             a key is currently held
//   ascii                ASCII of key_code under shift/caps
//   press_count          non-repeat make counter (wraps)
//   err_ovf              sticky overflow seen since reset
module ps2_kbd_ctrl #(
    parameter int CNT_W   = 8,
    parameter int PFX_TMO = 65535
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             rx_ready,
    input  logic [7:0]       rx_data,
    input  logic             rx_overflow,
    output logic             nextdata_n,
    output logic             key_event,
    output logic             key_release,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic [7:0]       ascii,
    output logic [CNT_W-1:0] press_count,
    output logic             err_ovf
);
    import ps2_kbd_ctrl_pkg::*;

    localparam int             TMO_W    = (PFX_TMO > 1) ? $clog2(PFX_TMO + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PFX_TMO - 1);

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             decode;
    logic [7:0]       code_r;
    logic             brk;
    logic             ext;
    logic             shift_l;
    logic             shift_r;
    logic             caps;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             held_match;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        decode     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_ready) begin
                    load       = 1'b1;
                    state_next = ST_POP;
                end
            end
            ST_POP:  state_next = ST_DEC;
            ST_DEC: begin
                decode     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A repeated make of the held key (same code and same E0 qualifier) is typematic.
    assign held_match = key_down && (code_r == key_code) && (ext == key_ext);

    // The prefix clock only runs while waiting in IDLE with no byte offered, so a
    // byte that is already on its way never loses its prefix.
    assign tmo_hit = (brk || ext) && (state == ST_IDLE) && !rx_ready && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            nextdata_n  <= 1'b1;
            code_r      <= 8'h00;
            key_event   <= 1'b0;
            key_release <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_down    <= 1'b0;
            press_count <= '0;
            err_ovf     <= 1'b0;
            brk         <= 1'b0;
            ext         <= 1'b0;
            shift_l     <= 1'b0;
            shift_r     <= 1'b0;
            caps        <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            key_event   <= 1'b0;
            key_release <= 1'b0;
            nextdata_n  <= !load;
            if (load) begin
                code_r <= rx_data;
            end

            if (!(brk || ext) || (state != ST_IDLE)) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_LAST) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (decode) begin
                if (code_r == SC_BREAK) begin
                    brk <= 1'b1;
                end else if (code_r == SC_EXT) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (is_shift(code_r)) begin
                        if (code_r == SC_LSHIFT) begin
                            shift_l <= !brk;
                        end else begin
                            shift_r <= !brk;
                        end
                    end else if (!brk) begin
                        if (!held_match) begin
                            if (code_r == SC_CAPS) begin
                                caps <= !caps;
                            end
                            key_code    <= code_r;
                            key_ext     <= ext;
                            key_down    <= 1'b1;
                            key_event   <= 1'b1;
                            press_count <= press_count + CNT_W'(1);
                        end
                    end else if (held_match) begin
                        key_down    <= 1'b0;
                        key_release <= 1'b1;
                    end
                end
            end

            // An overflow means bytes were lost, so any pending prefix no longer
            // belongs to the byte that follows it.
            if (rx_overflow) begin
                err_ovf <= 1'b1;
            end
            if (rx_overflow || tmo_hit) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end
        end
    end

    ps2_scan2ascii u_scan2ascii (
        .code  (key_code),
        .ext   (key_ext),
        .shift (shift_l | shift_r),
        .caps  (caps),
        .ascii (ascii)
    );

    logic unused_prefix_fn;
    assign unused_prefix_fn = is_prefix(code_r);

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - self-checking bench for ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;

    localparam int CNT_W   = 8;
    localparam int PFX_TMO = 40;

    logic             clk = 1'b0;
    logic             clrn = 1'b0;
    logic             rx_ready = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_overflow = 1'b0;
    logic             nextdata_n;
    logic             key_event;
    logic             key_release;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_down;
    logic [7:0]       ascii;
    logic [CNT_W-1:0] press_count;
    logic             err_ovf;

    always #5 clk = ~clk;

    ps2_kbd_ctrl #(.CNT_W(CNT_W), .PFX_TMO(PFX_TMO)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_overflow (rx_overflow),
        .nextdata_n  (nextdata_n),
        .key_event   (key_event),
        .key_release (key_release),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_down    (key_down),
        .ascii       (ascii),
        .press_count (press_count),
        .err_ovf     (err_ovf)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Receiver FIFO model: head is presented while non-empty, popped on the strobe.
    logic [7:0] fifo[$];
    logic       prev_nd = 1'b1;
    int         pop_cnt = 0;

    always @(negedge clk) begin
        if (!nextdata_n) begin
            n_cmp++;
            if (!prev_nd || !rx_ready) begin
                n_fail++;
                $display("FAIL pop_strobe: prev_nd=%0b rx_ready=%0b", prev_nd, rx_ready);
            end
            if (fifo.size() > 0) void'(fifo.pop_front());
            pop_cnt++;
        end
        prev_nd  = nextdata_n;
        rx_ready = (fifo.size() > 0);
        rx_data  = rx_ready ? fifo[0] : 8'h00;
    end

    typedef struct packed {
        logic       rel;
        logic [7:0] code;
        logic       ext;
        logic [7:0] asc;
        logic [7:0] cnt;
        logic       down;
    } ev_t;

    ev_t        dut_q[$];
    ev_t        exp_q[$];
    int         ev_cnt = 0;
    int         rel_cnt = 0;
    logic [7:0] first_asc = 8'h00;
    logic [7:0] last_asc = 8'h00;

    always @(negedge clk) begin
        if (clrn) begin
            if (key_event) begin
                dut_q.push_back('{1'b0, key_code, key_ext, ascii, press_count, key_down});
                ev_cnt++;
                if (ev_cnt == 1) first_asc = ascii;
                last_asc = ascii;
            end
            if (key_release) begin
                dut_q.push_back('{1'b1, key_code, key_ext, ascii, press_count, key_down});
                rel_cnt++;
            end
        end
    end

    task automatic clear_counts();
        ev_cnt  = 0;
        rel_cnt = 0;
        pop_cnt = 0;
        dut_q.delete();
        exp_q.delete();
    endtask

    task automatic drain();
        int i = 0;
        while (fifo.size() > 0 && i < 3000) begin
            @(posedge clk);
            i++;
        end
        check("drain", fifo.size(), 0);
        repeat (6) @(posedge clk);
        #2;
    endtask

    // Reference model: byte-level keyboard semantics.
    localparam logic [7:0] LET_SC [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
        8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIG_SC [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};

    function automatic logic [7:0] m_ascii(input logic [7:0] c, input logic e,
                                           input logic sh, input logic cp);
        string dsh = ")!@#$%^&*(";
        if (e) return 8'h00;
        for (int i = 0; i < 26; i++)
            if (LET_SC[i] == c) return ((sh ^ cp) ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (DIG_SC[i] == c) return sh ? dsh[i] : 8'h30 + 8'(i);
        case (c)
            8'h29:   return 8'h20;
            8'h5A:   return 8'h0D;
            8'h4E:   return sh ? 8'h5F : 8'h2D;
            8'h55:   return sh ? 8'h2B : 8'h3D;
            default: return 8'h00;
        endcase
    endfunction

    logic       m_brk, m_ext, m_shl, m_shr, m_caps, m_down, m_kext;
    logic [7:0] m_code, m_cnt;

    task automatic m_reset();
        m_brk = 0; m_ext = 0; m_shl = 0; m_shr = 0; m_caps = 0;
        m_down = 0; m_kext = 0; m_code = 8'h00; m_cnt = 8'h00;
    endtask

    task automatic m_apply(input logic [7:0] b);
        logic same;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            same = m_down && (b == m_code) && (m_ext == m_kext);
            if (b == 8'h12) m_shl = !m_brk;
            else if (b == 8'h59) m_shr = !m_brk;
            else if (!m_brk) begin
                if (!same) begin
                    if (b == 8'h58) m_caps = !m_caps;
                    m_code = b; m_kext = m_ext; m_down = 1; m_cnt = m_cnt + 8'd1;
                    exp_q.push_back('{1'b0, m_code, m_kext,
                                      m_ascii(m_code, m_kext, m_shl | m_shr, m_caps), m_cnt, 1'b1});
                end
            end else if (same) begin
                m_down = 0;
                exp_q.push_back('{1'b1, m_code, m_kext,
                                  m_ascii(m_code, m_kext, m_shl | m_shr, m_caps), m_cnt, 1'b0});
            end
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    typedef struct {
        logic [63:0] seq;
        int          n;
        int          ev;
        int          rel;
        logic [7:0]  af;
        logic [7:0]  al;
        logic [7:0]  code;
        logic        ext;
        logic        down;
        int          dcnt;
    } vec_t;

    vec_t       vt [14];
    logic [7:0] exp_count;
    logic [7:0] pool [16];
    int         found;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{64'h1C_F0_1C,             3, 1, 1, 8'h61, 8'h61, 8'h1C, 1'b0, 1'b0, 1};
        vt[1]  = '{64'h12_1C_F0_1C_F0_12,    6, 1, 1, 8'h41, 8'h41, 8'h1C, 1'b0, 1'b0, 1};
        vt[2]  = '{64'h1C_1C_1C_1C_1C_F0_1C, 7, 1, 1, 8'h61, 8'h61, 8'h1C, 1'b0, 1'b0, 1};
        vt[3]  = '{64'hE0_75_E0_F0_75,       5, 1, 1, 8'h00, 8'h00, 8'h75, 1'b1, 1'b0, 1};
        vt[4]  = '{64'h16_1B,                2, 2, 0, 8'h31, 8'h73, 8'h1B, 1'b0, 1'b1, 2};
        vt[5]  = '{64'hF0_16,                2, 0, 0, 8'h00, 8'h00, 8'h1B, 1'b0, 1'b1, 0};
        vt[6]  = '{64'hF0_1B,                2, 0, 1, 8'h00, 8'h00, 8'h1B, 1'b0, 1'b0, 0};
        vt[7]  = '{64'h58_F0_58_1C_F0_1C,    6, 2, 2, 8'h00, 8'h41, 8'h1C, 1'b0, 1'b0, 2};
        vt[8]  = '{64'h12_15_F0_15_F0_12,    6, 1, 1, 8'h71, 8'h71, 8'h15, 1'b0, 1'b0, 1};
        vt[9]  = '{64'h58_F0_58,             3, 1, 1, 8'h00, 8'h00, 8'h58, 1'b0, 1'b0, 1};
        vt[10] = '{64'h59_16_F0_16_F0_59,    6, 1, 1, 8'h21, 8'h21, 8'h16, 1'b0, 1'b0, 1};
        vt[11] = '{64'h58_58_58_F0_58,       5, 1, 1, 8'h00, 8'h00, 8'h58, 1'b0, 1'b0, 1};
        vt[12] = '{64'h1C_F0_1C,             3, 1, 1, 8'h41, 8'h41, 8'h1C, 1'b0, 1'b0, 1};
        vt[13] = '{64'h58_F0_58,             3, 1, 1, 8'h00, 8'h00, 8'h58, 1'b0, 1'b0, 1};

        pool = '{8'hF0, 8'hF0, 8'hE0, 8'h12, 8'h59, 8'h58, 8'h1C, 8'h1C,
                 8'h1B, 8'h16, 8'h75, 8'h29, 8'h45, 8'h4E, 8'h5A, 8'h15};

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_nextdata_n", nextdata_n, 1);
        check("rst_key_event", key_event, 0);
        check("rst_key_down", key_down, 0);
        check("rst_key_code", key_code, 0);
        check("rst_ascii", ascii, 0);
        check("rst_press_count", press_count, 0);
        check("rst_err_ovf", err_ovf, 0);
        clrn = 1'b1;
        @(posedge clk);
        #2;
        exp_count = 8'h00;

        // Directed table
        for (int r = 0; r < 14; r++) begin
            clear_counts();
            for (int i = 0; i < vt[r].n; i++)
                fifo.push_back(vt[r].seq[8*(vt[r].n-1-i) +: 8]);
            drain();
            exp_count = exp_count + 8'(vt[r].dcnt);
            check($sformatf("row%0d_events", r), ev_cnt, vt[r].ev);
            check($sformatf("row%0d_releases", r), rel_cnt, vt[r].rel);
            check($sformatf("row%0d_pops", r), pop_cnt, vt[r].n);
            check($sformatf("row%0d_key_code", r), key_code, vt[r].code);
            check($sformatf("row%0d_key_ext", r), key_ext, vt[r].ext);
            check($sformatf("row%0d_key_down", r), key_down, vt[r].down);
            check($sformatf("row%0d_press_count", r), press_count, exp_count);
            if (vt[r].ev > 0) begin
                check($sformatf("row%0d_ascii_first", r), first_asc, vt[r].af);
                check($sformatf("row%0d_ascii_last", r), last_asc, vt[r].al);
            end
        end

        // Event latency: ready sampled at end of cycle t, strobe in t+1, event in t+3
        clear_counts();
        fifo.push_back(8'h1C);
        @(posedge clk); #1;
        check("lat_t1_nextdata_n", nextdata_n, 0);
        check("lat_t1_key_event", key_event, 0);
        @(posedge clk); #1;
        check("lat_t2_nextdata_n", nextdata_n, 1);
        check("lat_t2_key_event", key_event, 0);
        @(posedge clk); #1;
        check("lat_t3_key_event", key_event, 1);
        check("lat_t3_key_down", key_down, 1);
        check("lat_t3_ascii", ascii, 8'h61);
        @(posedge clk); #1;
        check("lat_t4_key_event", key_event, 0);
        #1;
        fifo.push_back(8'hF0);
        fifo.push_back(8'h1C);
        drain();
        exp_count = exp_count + 8'd1;
        check("lat_releases", rel_cnt, 1);
        check("lat_press_count", press_count, exp_count);

        // Prefix timeout: a stale F0 is dropped, a fresh one is honoured
        clear_counts();
        fifo.push_back(8'hF0);
        drain();
        repeat (PFX_TMO + 10) @(posedge clk);
        #2;
        fifo.push_back(8'h1C);
        drain();
        exp_count = exp_count + 8'd1;
        check("tmo_make_event", ev_cnt, 1);
        check("tmo_key_down", key_down, 1);
        check("tmo_press_count", press_count, exp_count);
        clear_counts();
        fifo.push_back(8'hF0);
        drain();
        repeat (10) @(posedge clk);
        #2;
        fifo.push_back(8'h1C);
        drain();
        check("pfx_alive_release", rel_cnt, 1);
        check("pfx_alive_events", ev_cnt, 0);
        check("pfx_alive_key_down", key_down, 0);

        // Overflow: sticky flag, pending break discarded
        clear_counts();
        fifo.push_back(8'hF0);
        drain();
        rx_overflow = 1'b1;
        @(posedge clk); #2;
        rx_overflow = 1'b0;
        check("ovf_set", err_ovf, 1);
        fifo.push_back(8'h1C);
        drain();
        exp_count = exp_count + 8'd1;
        check("ovf_make_event", ev_cnt, 1);
        check("ovf_key_down", key_down, 1);
        fifo.push_back(8'hF0);
        fifo.push_back(8'h1C);
        drain();
        repeat (20) @(posedge clk);
        #2;
        check("ovf_sticky", err_ovf, 1);
        check("ovf_press_count", press_count, exp_count);

        // Asynchronous reset while a byte sits between POP and DEC
        clear_counts();
        fifo.push_back(8'h1C);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!nextdata_n) begin
                found = 1;
                break;
            end
        end
        check("arst_pop_seen", found, 1);
        @(posedge clk); #2;
        clrn = 1'b0;
        #1;
        check("arst_nextdata_n", nextdata_n, 1);
        check("arst_key_event", key_event, 0);
        check("arst_key_code", key_code, 0);
        check("arst_key_down", key_down, 0);
        check("arst_press_count", press_count, 0);
        check("arst_err_ovf", err_ovf, 0);
        check("arst_ascii", ascii, 0);
        @(posedge clk); #2;
        clrn = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("arst_no_event", ev_cnt, 0);
        check("arst_count_after", press_count, 0);

        // Randomised byte streams against the reference model
        m_reset();
        for (int batch = 0; batch < 10; batch++) begin
            clear_counts();
            for (int k = 0; k < 30; k++) begin
                logic [7:0] b;
                int gap;
                b = pool[$urandom_range(0, 15)];
                m_apply(b);
                fifo.push_back(b);
                gap = $urandom_range(0, 3);
                if (gap > 0) begin
                    repeat (gap) @(posedge clk);
                    #2;
                end
            end
            drain();
            check($sformatf("rnd%0d_event_total", batch), dut_q.size(), exp_q.size());
            for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++)
                check($sformatf("rnd%0d_ev%0d", batch, i), dut_q[i], exp_q[i]);
            check($sformatf("rnd%0d_key_down", batch), key_down, m_down);
            check($sformatf("rnd%0d_press_count", batch), press_count, m_cnt);
            check($sformatf("rnd%0d_ascii", batch), ascii,
                  m_ascii(m_code, m_kext, m_shl | m_shr, m_caps));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
